// File: rtl/npc_mem_pkg.sv
// npc_mem_pkg: shared state encoding and default parameters for the memory responder
package npc_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;
  localparam int unsigned DEF_LATENCY = 2;
  localparam int unsigned DEF_DEPTH_WORDS = 1024;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
endpackage

// File: rtl/mem_resp_store.sv
// mem_resp_store: word array with byte-masked synchronous write and combinational read, no reset
module mem_resp_store
  import npc_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wmask,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency single-outstanding memory target with byte-masked writes
module mem_responder
  import npc_mem_pkg::*;
#(
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d, wmask_q, wmask_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, off, mem_rdata;
  logic wen_q, wen_d, err_q, err_d, in_range, we;
  assign off = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, off} < (33'(DEPTH_WORDS) << 2));
  assign req_ready = (state_q == IDLE) && !rst;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
  mem_resp_store #(.DEPTH_WORDS(DEPTH_WORDS)) u_store (
    .clk  (clk),
    .we   (we),
    .addr (off[AW+1:2]),
    .wdata(wdata_q),
    .wmask(wmask_q),
    .rdata(mem_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wen_d = wen_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d = err_q;
    we = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = BUSY;
        cnt_d = 4'(LATENCY - 1);
        wen_d = req_wen;
        addr_d = req_addr;
        wdata_d = req_wdata;
        wmask_d = req_wmask;
      end
      BUSY: if (cnt_q == 4'd0) begin
        state_d = RESP;
        we = wen_q && in_range && !rst;
        rdata_d = (!wen_q && in_range) ? mem_rdata : 32'd0;
        err_d = !in_range;
      end else cnt_d = cnt_q - 4'd1;
      RESP: if (resp_ready) begin
        state_d = IDLE;
        rdata_d = 32'd0;
        err_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      wen_q <= 1'b0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wen_q <= wen_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table, directed and randomized checks of mem_responder against a word-array model
module tb_mem_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 1024;
  localparam int LAT = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_wmask = '0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic req_valid1 = 1'b0, req_wen1 = 1'b0, resp_ready1 = 1'b0;
  logic [31:0] req_addr1 = '0, req_wdata1 = '0;
  logic [3:0] req_wmask1 = '0;
  logic req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1;
  int cmp = 0, bad = 0;
  logic [31:0] mm [DEPTH];
  typedef struct {
    logic w;
    logic [31:0] a, d;
    logic [3:0] m;
    logic [31:0] xr;
    logic xe;
  } vec_t;
  vec_t tbl[14];
  always #5 clk = ~clk;
  mem_responder u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  mem_responder #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_wen(req_wen1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_wmask(req_wmask1), .resp_valid(resp_valid1),
    .resp_ready(resp_ready1), .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       output logic [31:0] r, output logic e);
    longint unsigned x = a;
    bit in = x >= longint'(BASE) && x < longint'(BASE) + 4 * DEPTH;
    r = 32'd0;
    e = !in;
    if (in) begin
      int i = int'((x - longint'(BASE)) / 4);
      if (w) begin
        for (int b = 0; b < 4; b++) if (m[b]) mm[i][8*b +: 8] = d[8*b +: 8];
      end else r = mm[i];
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                        input int stall, output logic [31:0] r, output logic e);
    int k = 0;
    while (!req_ready && k < 20) begin tick(); k++; end
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = w; req_addr = a; req_wdata = d; req_wmask = m; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    req_wen = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_wmask = 4'($urandom);
    k = 0;
    while (!resp_valid && k < 40) begin tick(); k++; end
    chk("latency", 32'(k), 32'(LAT));
    r = resp_rdata;
    e = resp_err;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, r);
      chk("stall_err", 32'(resp_err), 32'(e));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 32'd0);
    chk("post_rdata", resp_rdata, 32'd0);
    chk("post_err", 32'(resp_err), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
  endtask
  task automatic rst_mid_busy(input int d);
    logic [31:0] r;
    logic e;
    do_req(1'b1, BASE + 32'h40, 32'h1234_5678, 4'hF, 0, r, e);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE + 32'h40; req_wdata = 32'h5555_5555; req_wmask = 4'hF;
    tick();
    req_valid = 1'b0;
    repeat (d - 1) tick();
    rst = 1'b1;
    tick();
    chk("rstb_req_ready", 32'(req_ready), 32'd0);
    chk("rstb_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rstb_ready_after", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstb_no_resp", 32'(resp_valid), 32'd0);
    end
    do_req(1'b0, BASE + 32'h40, 32'h0, 4'h0, 0, r, e);
    chk("rstb_word_kept", r, 32'h1234_5678);
    mm[16] = 32'h1234_5678;
  endtask
  initial begin
    logic [31:0] r, xr, la[8], ld[8], lx[8], a, dd, pr;
    logic e, xe, w, pa, ph, lw[8];
    logic [3:0] m;
    int ni, nr, last, cyc;
    tbl[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0};
    tbl[4]  = '{1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0};
    tbl[5]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
    tbl[6]  = '{1'b1, 32'h7FFF_FFFC, 32'h0123_4567, 4'hF, 32'h0, 1'b1};
    tbl[7]  = '{1'b0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1'b1};
    tbl[8]  = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0};
    tbl[9]  = '{1'b1, 32'h8000_0FFC, 32'h0BAD_C0DE, 4'hF, 32'h0, 1'b0};
    tbl[10] = '{1'b0, 32'h8000_0FFE, 32'h0, 4'h0, 32'h0BAD_C0DE, 1'b0};
    tbl[11] = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
    tbl[12] = '{1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0};
    tbl[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1};
    repeat (3) tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(req_ready), 32'd1);
    chk("rst_release_ready1", 32'(req_ready1), 32'd1);
    tick();
    chk("idle_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 14; i++) begin
      do_req(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].m, 0, r, e);
      model(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].m, xr, xe);
      chk($sformatf("tbl%0d_rdata", i), r, tbl[i].xr);
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].xe));
    end
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, 5, r, e);
    chk("bp_rdata", r, 32'hDEAD_BEEF);
    chk("bp_err", 32'(e), 32'd0);
    rst_mid_busy(1);
    rst_mid_busy(2);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE + 32'h48; req_wdata = 32'hA5A5_A5A5; req_wmask = 4'hF;
    tick();
    req_valid = 1'b0;
    repeat (LAT) tick();
    chk("rstr_in_resp", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstr_valid", 32'(resp_valid), 32'd0);
    chk("rstr_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    model(1'b1, BASE + 32'h48, 32'hA5A5_A5A5, 4'hF, xr, xe);
    do_req(1'b0, BASE + 32'h48, 32'h0, 4'h0, 0, r, e);
    chk("rstr_committed", r, 32'hA5A5_A5A5);
    for (int i = 0; i < 16; i++) begin
      dd = $urandom;
      do_req(1'b1, BASE + 32'(4 * i), dd, 4'hF, 0, r, e);
      model(1'b1, BASE + 32'(4 * i), dd, 4'hF, xr, xe);
      chk("fill_err", 32'(e), 32'(xe));
    end
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, 7) == 0 ?
          ($urandom_range(0, 1) == 0 ? ($urandom_range(0, 1) == 0 ? BASE - 32'd4 : BASE + 32'(4 * DEPTH))
                                     : ($urandom_range(0, 1) == 0 ? 32'h0 : 32'hFFFF_FFFC)) :
          BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      w = 1'($urandom);
      m = 4'($urandom);
      dd = $urandom;
      do_req(w, a, dd, m, $urandom_range(0, 3), r, e);
      model(w, a, dd, m, xr, xe);
      chk("rnd_rdata", r, xr);
      chk("rnd_err", 32'(e), 32'(xe));
    end
    for (int i = 0; i < 4; i++) begin
      la[i] = BASE + 32'h100 + 32'(4 * i); ld[i] = $urandom; lw[i] = 1'b1; lx[i] = 32'h0;
      la[i+4] = la[i]; ld[i+4] = 32'h0; lw[i+4] = 1'b0; lx[i+4] = ld[i];
    end
    ni = 0; nr = 0; last = 0; cyc = 0;
    req_valid1 = 1'b1; req_wen1 = lw[0]; req_addr1 = la[0]; req_wdata1 = ld[0]; req_wmask1 = 4'hF;
    resp_ready1 = 1'b1;
    while (nr < 8 && cyc < 100) begin
      pa = req_valid1 && req_ready1;
      ph = resp_valid1;
      pr = resp_rdata1;
      tick();
      cyc++;
      if (pa) begin
        ni++;
        if (ni < 8) begin req_wen1 = lw[ni]; req_addr1 = la[ni]; req_wdata1 = ld[ni]; end
        else req_valid1 = 1'b0;
      end
      if (ph) begin
        chk("lat1_rdata", pr, lx[nr]);
        if (nr > 0) chk("lat1_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        nr++;
      end
    end
    chk("lat1_count", 32'(nr), 32'd8);
    resp_ready1 = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
